frame_capture_ctrl: RTL and testbench
=====================================

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter H_PIX, default 320: stored pixels per line.
REQ-002 SHALL have parameter V_LINES, default 240: stored lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17: frame buffer address width.
REQ-004 SHALL have port pclk  in  1  pixel clock; sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port vsync  in  1  camera frame sync.
REQ-007 SHALL have port href  in  1  camera line valid.
REQ-008 SHALL have port d  in  8  camera byte stream (RGB444, 2 bytes/pixel).
REQ-009 SHALL have port mode  in  1  0 = continuous, 1 = single-shot.
REQ-010 SHALL have port start  in  1  single-shot request; one-cycle pulse.
REQ-011 SHALL have port freeze  in  1  level; blocks any new frame.
REQ-012 SHALL have port addr  out  ADDR_W  frame buffer write address.
REQ-013 SHALL have port dout  out  12  pixel {R,G,B}.
REQ-014 SHALL have port we  out  1  write strobe, one cycle per pixel.
REQ-015 SHALL have port busy  out  1  high in ARM or CAPTURE.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse per completed frame.
REQ-017 SHALL have port frame_cnt  out  8  completed frames, wraps 255->0.
REQ-018 SHALL have port ovf  out  1  sticky; a write past the last address was suppressed.

Function
REQ-019 SHALL register vsync and href once.
REQ-020 SHALL treat a rising edge of the registered vsync as the frame boundary (vs_rise).
REQ-021 SHALL have states IDLE, ARM, CAPTURE, DONE.
REQ-022 IDLE: go to ARM next cycle if mode=0 and freeze=0, or if mode=1 and start=1.
REQ-023 ARM: go to CAPTURE on vs_rise; pixel address and byte phase cleared to 0.
REQ-024 An edge coinciding with the IDLE->ARM transition SHALL NOT be consumed; ARM waits for the next vs_rise.
REQ-025 CAPTURE: byte phase SHALL toggle each cycle href is high and clear when href is low.
REQ-026 CAPTURE, phase 0: capture R = d[3:0].
REQ-027 CAPTURE, phase 1: G = d[7:4], B = d[3:0], and issue a write.
REQ-028 Write timing: we, addr and dout SHALL be valid on the cycle after the phase-1 byte is sampled (latency 1).
REQ-029 Write address: addr SHALL equal the pixel index; the index increments after each write.
REQ-030 Full buffer: when the index reaches H_PIX*V_LINES, further writes SHALL be suppressed (we=0), ovf set, and addr held at H_PIX*V_LINES-1.
REQ-031 CAPTURE: on vs_rise go to DONE for one cycle; frame_done=1 and frame_cnt increments.
REQ-032 DONE: go to CAPTURE (addr and phase cleared) if mode=0 and freeze=0; otherwise go to IDLE.
REQ-033 A short frame (fewer pixels than the buffer) SHALL still complete normally, with ovf unchanged.
REQ-034 freeze asserted mid-frame SHALL let the current frame finish; no further frame is started.
REQ-035 start outside IDLE SHALL be ignored.
REQ-036 we SHALL be 0 in IDLE, ARM and DONE.

Reset
REQ-037 On rst=1 at a clock edge, the next cycle SHALL have: state IDLE, addr=0, dout=0, we=0, busy=0, frame_done=0, frame_cnt=0, ovf=0, byte phase 0.
REQ-038 Reset mid-frame SHALL abort the frame with no further writes; capture restarts only at a fresh vs_rise after ARM.

Configuration
REQ-039 SHALL support macro FRAME_CAPTURE_DECIMATE_EN.
REQ-040 When FRAME_CAPTURE_DECIMATE_EN is defined, only even pixels of even lines SHALL be written (640x480 source into a 320x240 buffer).
REQ-041 Decimation counting: line parity SHALL toggle on each href falling edge; both pixel and line counters clear at the frame start.
REQ-042 When FRAME_CAPTURE_DECIMATE_EN is undefined, every pixel SHALL be written and no line counter SHALL exist.

Verification
REQ-043 Continuous, undecimated: rst, mode=0, two 4-line x 4-pixel frames with H_PIX=4, V_LINES=4 -> 16 writes per frame with addr 0..15; frame_done twice; frame_cnt=2; ovf=0.
REQ-044 Pixel packing: bytes 0x0A then 0x5C -> dout=0xA5C with we=1 exactly one cycle after the 0x5C byte.
REQ-045 Overflow: 5 lines x 4 pixels into H_PIX=4, V_LINES=4 -> 16 writes; addr holds at 15; ovf=1 and stays 1 until rst.
REQ-046 Single-shot: mode=1; start pulsed in the same cycle as vs_rise -> first frame skipped, second frame captured, then IDLE with busy=0; start during CAPTURE is ignored.
REQ-047 Freeze and reset: freeze=1 mid-frame -> frame completes, frame_done=1, then IDLE; rst asserted mid-frame -> we=0 from the next cycle and all outputs at reset values.
REQ-048 Decimation: with FRAME_CAPTURE_DECIMATE_EN defined and an 8x8 source into a 4x4 buffer -> 16 writes, drawn only from even pixels of even lines.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - camera frame capture FSM into a frame buffer; define FRAME_CAPTURE_DECIMATE_EN for 2:1 decimation
module frame_capture_ctrl #(
    parameter int H_PIX   = 320,
    parameter int V_LINES = 240,
    parameter int ADDR_W  = 17
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              mode,
    input  logic              start,
    input  logic              freeze,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              ovf
);
    localparam int TOTAL = H_PIX * V_LINES;
    // pixel index is one bit wider so a buffer filling the whole address space still has a distinct full value
    localparam logic [ADDR_W:0]   FULL_IDX = (ADDR_W + 1)'(TOTAL);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t          state;
    logic            vs_r, vs_prev, href_r;
    logic [7:0]      d_r;
    logic            phase;
    logic [3:0]      r_hold;
    logic [ADDR_W:0] pix_idx;
    logic            vs_rise;
    logic            keep;

    assign vs_rise = vs_r & ~vs_prev;

`ifdef FRAME_CAPTURE_DECIMATE_EN
    logic href_prev, col_odd, line_odd;
    assign keep = ~col_odd & ~line_odd;
`else
    assign keep = 1'b1;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            vs_r       <= 1'b0;
            vs_prev    <= 1'b0;
            href_r     <= 1'b0;
            d_r        <= 8'd0;
            phase      <= 1'b0;
            r_hold     <= 4'd0;
            pix_idx    <= '0;
            addr       <= '0;
            dout       <= 12'd0;
            we         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            ovf        <= 1'b0;
`ifdef FRAME_CAPTURE_DECIMATE_EN
            href_prev  <= 1'b0;
            col_odd    <= 1'b0;
            line_odd   <= 1'b0;
`endif
        end else begin
            vs_r       <= vsync;
            vs_prev    <= vs_r;
            href_r     <= href;
            d_r        <= d;
            we         <= 1'b0;
            frame_done <= 1'b0;
`ifdef FRAME_CAPTURE_DECIMATE_EN
            href_prev  <= href_r;
`endif
            case (state)
                IDLE: begin
                    if ((!mode && !freeze) || (mode && start)) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (freeze) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vs_rise) begin
                        state   <= CAPTURE;
                        pix_idx <= '0;
                        addr    <= '0;
                        phase   <= 1'b0;
`ifdef FRAME_CAPTURE_DECIMATE_EN
                        col_odd  <= 1'b0;
                        line_odd <= 1'b0;
`endif
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        phase      <= 1'b0;
                    end else begin
                        if (href_r) begin
                            phase <= ~phase;
                            if (!phase) begin
                                r_hold <= d_r[3:0];
                            end else begin
`ifdef FRAME_CAPTURE_DECIMATE_EN
                                col_odd <= ~col_odd;
`endif
                                if (keep) begin
                                    if (pix_idx == FULL_IDX) begin
                                        ovf  <= 1'b1;
                                        addr <= LAST;
                                    end else begin
                                        we      <= 1'b1;
                                        addr    <= pix_idx[ADDR_W-1:0];
                                        dout    <= {r_hold, d_r};
                                        pix_idx <= pix_idx + 1'b1;
                                    end
                                end
                            end
                        end else begin
                            phase <= 1'b0;
                        end
`ifdef FRAME_CAPTURE_DECIMATE_EN
                        if (href_prev && !href_r) begin
                            line_odd <= ~line_odd;
                            col_odd  <= 1'b0;
                        end
`endif
                    end
                end
                DONE: begin
                    // the vs_rise that closed the last frame also opens the next one
                    if (!mode && !freeze) begin
                        state   <= CAPTURE;
                        busy    <= 1'b1;
                        pix_idx <= '0;
                        addr    <= '0;
                        phase   <= 1'b0;
`ifdef FRAME_CAPTURE_DECIMATE_EN
                        col_odd  <= 1'b0;
                        line_odd <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - scoreboard bench for frame_capture_ctrl
module tb_frame_capture_ctrl;
    localparam int H = 4;
    localparam int V = 4;
    localparam int AW = 8;
    localparam int TOTAL = H * V;
`ifdef FRAME_CAPTURE_DECIMATE_EN
    localparam int SC = 2;
    localparam bit DEC = 1'b1;
`else
    localparam int SC = 1;
    localparam bit DEC = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          rst, vsync, href, mode, start, freeze;
    logic [7:0]    d;
    logic [AW-1:0] addr;
    logic [11:0]   dout;
    logic          we, busy, frame_done, ovf;
    logic [7:0]    frame_cnt;

    frame_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d),
        .mode(mode), .start(start), .freeze(freeze),
        .addr(addr), .dout(dout), .we(we), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .ovf(ovf)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [11:0] exp;
    } vec_t;
    typedef struct {
        logic [AW-1:0] a;
        logic [11:0]   p;
    } wr_t;

    vec_t tbl[8];
    wr_t  sb[$];
    wr_t  got;
    int   total = 0;
    int   bad = 0;
    int   wr_count = 0;
    int   fd_count = 0;
    int   m_idx, m_px, m_line;
    bit   m_cap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (frame_done) fd_count++;
        if (we) begin
            wr_count++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0h dout=%0h expected no write", addr, dout);
            end else begin
                got = sb.pop_front();
                check("wr_addr", 32'(addr), 32'(got.a));
                check("wr_dout", 32'(dout), 32'(got.p));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge pclk);
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        tick(2);
        vsync = 1'b0;
        tick(3);
    endtask

    task automatic frame_begin(input bit cap);
        m_cap = cap;
        m_idx = 0;
        m_px = 0;
        m_line = 0;
    endtask

    task automatic model_pixel(input logic [11:0] exp);
        wr_t w;
        bit  keep;
        keep = !DEC || ((m_px % 2 == 0) && (m_line % 2 == 0));
        if (m_cap && keep) begin
            if (m_idx < TOTAL) begin
                w.a = AW'(m_idx);
                w.p = exp;
                sb.push_back(w);
            end
            m_idx++;
        end
        m_px++;
    endtask

    task automatic drive_pixel(input logic [7:0] b0, input logic [7:0] b1, input logic [11:0] exp);
        href = 1'b1;
        d = b0;
        tick(1);
        d = b1;
        tick(1);
        model_pixel(exp);
    endtask

    task automatic line_end();
        href = 1'b0;
        d = 8'd0;
        tick(4);
        m_line++;
        m_px = 0;
    endtask

    task automatic send_lines(input int nl, input int np, input bit use_tbl);
        logic [7:0] b0, b1;
        int k;
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < np; p++) begin
                k = l * np + p;
                if (use_tbl && k < 8) begin
                    drive_pixel(tbl[k].b0, tbl[k].b1, tbl[k].exp);
                end else begin
                    b0 = 8'($urandom);
                    b1 = 8'($urandom);
                    drive_pixel(b0, b1, {b0[3:0], b1});
                end
            end
            line_end();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(addr), 0);
        check({tag, "_dout"}, 32'(dout), 0);
        check({tag, "_we"}, 32'(we), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
    endtask

    int w0, f0;

    initial begin
        tbl[0] = '{8'h0A, 8'h5C, 12'hA5C};
        tbl[1] = '{8'hFF, 8'h00, 12'hF00};
        tbl[2] = '{8'h30, 8'hAB, 12'h0AB};
        tbl[3] = '{8'h05, 8'hFF, 12'h5FF};
        tbl[4] = '{8'hC7, 8'h12, 12'h712};
        tbl[5] = '{8'h00, 8'h00, 12'h000};
        tbl[6] = '{8'h9E, 8'h81, 12'hE81};
        tbl[7] = '{8'h61, 8'h3D, 12'h13D};

        rst = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'd0;
        mode = 1'b0; start = 1'b0; freeze = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(3);
        check("cont_armed_busy", 32'(busy), 1);

        // continuous: two frames, freeze raised during the second
        vs_pulse();
        frame_begin(1);
        w0 = wr_count;
        send_lines(V * SC, H * SC, 1'b1);
        check("f1_writes", 32'(wr_count - w0), TOTAL);
        vs_pulse();
        check("f1_done_pulses", 32'(fd_count), 1);
        check("f1_frame_cnt", 32'(frame_cnt), 1);
        frame_begin(1);
        w0 = wr_count;
        send_lines(2 * SC, H * SC, 1'b0);
        freeze = 1'b1;
        send_lines(2 * SC, H * SC, 1'b0);
        vs_pulse();
        check("f2_writes", 32'(wr_count - w0), TOTAL);
        check("f2_done_pulses", 32'(fd_count), 2);
        check("f2_frame_cnt", 32'(frame_cnt), 2);
        check("f2_ovf", 32'(ovf), 0);
        check("freeze_idle_busy", 32'(busy), 0);
        frame_begin(0);
        send_lines(V * SC, H * SC, 1'b0);
        vs_pulse();
        check("freeze_frame_cnt", 32'(frame_cnt), 2);
        check("freeze_sb_empty", 32'(sb.size()), 0);

        // pixel packing and write latency
        freeze = 1'b0;
        tick(2);
        vs_pulse();
        frame_begin(1);
        href = 1'b1;
        d = 8'h0A;
        tick(1);
        d = 8'h5C;
        tick(1);
        model_pixel(12'hA5C);
        href = 1'b0;
        d = 8'd0;
        check("pack_we_early", 32'(we), 0);
        tick(1);
        check("pack_we", 32'(we), 1);
        check("pack_dout", 32'(dout), 32'h0A5C);
        tick(1);
        check("pack_we_after", 32'(we), 0);
        line_end();

        // overflow, then reset in the middle of a frame
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        vs_pulse();
        frame_begin(1);
        w0 = wr_count;
        send_lines(5 * SC, H * SC, 1'b0);
        check("ovf_writes", 32'(wr_count - w0), TOTAL);
        check("ovf_addr_hold", 32'(addr), TOTAL - 1);
        check("ovf_set", 32'(ovf), 1);
        vs_pulse();
        check("ovf_sticky", 32'(ovf), 1);
        check("ovf_frame_cnt", 32'(frame_cnt), 1);
        frame_begin(1);
        drive_pixel(8'h01, 8'h23, 12'h123);
        drive_pixel(8'h04, 8'h56, 12'h456);
        href = 1'b0;
        tick(3);
        check("ovf_sticky_next", 32'(ovf), 1);
        m_cap = 1'b0;
        href = 1'b1;
        d = 8'h07;
        tick(1);
        d = 8'h89;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        href = 1'b0;
        d = 8'd0;
        check_reset_outputs("midrst");
        w0 = wr_count;
        tick(3);
        check("midrst_armed", 32'(busy), 1);
        send_lines(1, H * SC, 1'b0);
        check("midrst_no_writes", 32'(wr_count - w0), 0);
        vs_pulse();
        frame_begin(1);
        send_lines(V * SC, H * SC, 1'b0);
        vs_pulse();
        check("midrst_restart_writes", 32'(wr_count - w0), TOTAL);
        check("midrst_frame_cnt", 32'(frame_cnt), 1);

        // single-shot
        rst = 1'b1;
        mode = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        check("ss_idle_busy", 32'(busy), 0);
        vsync = 1'b1;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        vsync = 1'b0;
        tick(3);
        check("ss_armed_busy", 32'(busy), 1);
        frame_begin(0);
        w0 = wr_count;
        f0 = fd_count;
        send_lines(V * SC, H * SC, 1'b0);
        check("ss_skip_writes", 32'(wr_count - w0), 0);
        vs_pulse();
        frame_begin(1);
        send_lines(2 * SC, H * SC, 1'b0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        send_lines(2 * SC, H * SC, 1'b0);
        vs_pulse();
        check("ss_writes", 32'(wr_count - w0), TOTAL);
        check("ss_done_pulses", 32'(fd_count - f0), 1);
        check("ss_frame_cnt", 32'(frame_cnt), 1);
        check("ss_idle_after", 32'(busy), 0);
        frame_begin(0);
        send_lines(V * SC, H * SC, 1'b0);
        vs_pulse();
        check("ss_no_rearm_cnt", 32'(frame_cnt), 1);
        check("ss_no_rearm_writes", 32'(wr_count - w0), TOTAL);
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
